div_ctrl: RTL and testbench

- M-extension divide front end, directly upstream of the serial divider (serdiv) in the EX stage.
- Accepts DIV/DIVU/REM/REMU from EX and stalls the pipeline while the op is in flight.
- Resolves RISC-V special cases (divide-by-zero, signed overflow) locally without starting the divider.
- Otherwise launches serdiv with a one-cycle start, waits for its end-valid, selects quotient or remainder, and returns a single-cycle writeback pulse.

---
 rtl/div_ctrl.sv | 145 ++++++++++++++
 tb/tb_div_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_ctrl
// Brief    : M-extension divide front end; resolves RISC-V special cases and
//            sequences the serial divider, returning a one-cycle writeback.
// Revision : 1.0 - initial release
// ============================================================================
module div_ctrl #(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_flush,
    input  logic            i_valid,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [4:0]      i_rd,
    output logic            o_stall,
    output logic            o_wb_valid,
    output logic [4:0]      o_wb_rd,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_div_flush,
    output logic            o_div_start,
    output logic            o_div_signed,
    output logic [XLEN-1:0] o_div_dividend,
    output logic [XLEN-1:0] o_div_divisor,
    input  logic            i_div_busy,
    input  logic            i_div_end_valid,
    input  logic [XLEN-1:0] i_div_quotient,
    input  logic [XLEN-1:0] i_div_remainder
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] c_ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] c_MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_signed;
    logic            r_sel_rem;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic            r_start;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;

    logic            w_is_div;
    logic            w_accept;
    logic            w_div_zero;
    logic            w_overflow;
    logic            w_special;
    logic            w_capture;
    logic [XLEN-1:0] w_special_q;
    logic [XLEN-1:0] w_special_r;
    logic [XLEN-1:0] w_special_res;

    assign w_is_div   = i_valid & i_funct3[2];
    assign w_accept   = (r_state == S_IDLE) & w_is_div & ~i_flush & ~i_div_busy;
    assign w_div_zero = (i_rs2 == '0);
    assign w_overflow = ~i_funct3[0] & (i_rs1 == c_MIN_NEG) & (i_rs2 == c_ALL_ONES);
    assign w_special  = FAST_SPECIAL & (w_div_zero | w_overflow);
    assign w_capture  = (r_state == S_WAIT) & i_div_end_valid & ~i_flush;

    // RISC-V defined results: x/0 = -1 rem x; MIN/-1 = MIN rem 0
    assign w_special_q   = w_div_zero ? c_ALL_ONES : c_MIN_NEG;
    assign w_special_r   = w_div_zero ? i_rs1 : '0;
    assign w_special_res = i_funct3[1] ? w_special_r : w_special_q;

    always_comb begin
        w_state_nxt = r_state;
        o_stall     = 1'b0;
        o_wb_valid  = 1'b0;
        o_div_flush = i_flush & ((r_state == S_WAIT) | r_start);
        case (r_state)
            S_IDLE: begin
                o_stall = w_is_div & ~i_flush & ~reset;
                if (w_accept) begin
                    w_state_nxt = w_special ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                o_stall = ~reset;
                if (i_div_end_valid) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_wb_valid  = ~i_flush;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_signed  <= 1'b0;
            r_sel_rem <= 1'b0;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_start   <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= w_accept & ~w_special;
            if (w_accept) begin
                r_signed  <= ~i_funct3[0];
                r_sel_rem <= i_funct3[1];
                r_rd      <= i_rd;
                r_rs1     <= i_rs1;
                r_rs2     <= i_rs2;
            end
            if (w_accept & w_special) begin
                r_wb_data <= w_special_res;
                r_wb_rd   <= i_rd;
            end else if (w_capture) begin
                r_wb_data <= r_sel_rem ? i_div_remainder : i_div_quotient;
                r_wb_rd   <= r_rd;
            end
        end
    end

    assign o_wb_rd        = r_wb_rd;
    assign o_wb_data      = r_wb_data;
    assign o_div_start    = r_start;
    assign o_div_signed   = r_signed;
    assign o_div_dividend = r_rs1;
    assign o_div_divisor  = r_rs2;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_ctrl
// Brief    : Scoreboard bench for div_ctrl with a behavioural serdiv model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

    localparam int XLEN = 32;
    localparam bit FAST = 1'b1;
    localparam logic [31:0] c_MIN_NEG  = 32'h8000_0000;
    localparam logic [31:0] c_ALL_ONES = 32'hFFFF_FFFF;

    logic        clk, reset, i_flush, i_valid;
    logic [2:0]  i_funct3;
    logic [31:0] i_rs1, i_rs2;
    logic [4:0]  i_rd;
    logic        o_stall, o_wb_valid, o_div_flush, o_div_start, o_div_signed;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data, o_div_dividend, o_div_divisor;
    logic        i_div_busy, i_div_end_valid;
    logic [31:0] i_div_quotient, i_div_remainder;

    div_ctrl #(.XLEN(XLEN), .FAST_SPECIAL(FAST)) dut (
        .clk(clk), .reset(reset), .i_flush(i_flush), .i_valid(i_valid),
        .i_funct3(i_funct3), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
        .o_stall(o_stall), .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd),
        .o_wb_data(o_wb_data), .o_div_flush(o_div_flush), .o_div_start(o_div_start),
        .o_div_signed(o_div_signed), .o_div_dividend(o_div_dividend),
        .o_div_divisor(o_div_divisor), .i_div_busy(i_div_busy),
        .i_div_end_valid(i_div_end_valid), .i_div_quotient(i_div_quotient),
        .i_div_remainder(i_div_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_start = 0;
    bit prev_start = 1'b0;
    logic [36:0] exp_q[$];
    int lat_min = 2;
    int lat_max = 8;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // RISC-V division semantics, plain arithmetic
    task automatic rv_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = c_ALL_ONES;
            r = a;
        end else if (sgn && a == c_MIN_NEG && b == c_ALL_ONES) begin
            q = c_MIN_NEG;
            r = 32'd0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Serial divider model: variable latency, optional drain time after result
    int          m_cnt, m_drain;
    bit          m_run;
    logic [31:0] m_q, m_r;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run <= 1'b0; m_cnt <= 0; m_drain <= 0;
            i_div_busy <= 1'b0; i_div_end_valid <= 1'b0;
            i_div_quotient <= '0; i_div_remainder <= '0;
        end else begin
            i_div_end_valid <= 1'b0;
            if (o_div_flush) begin
                m_run <= 1'b0; m_drain <= 0; i_div_busy <= 1'b0;
            end else if (o_div_start) begin
                check_eq("start_while_busy", {63'd0, i_div_busy}, 64'd0);
                rv_div(o_div_signed, o_div_dividend, o_div_divisor, m_q, m_r);
                i_div_quotient  <= m_q;
                i_div_remainder <= m_r;
                m_cnt <= $urandom_range(lat_max, lat_min);
                m_run <= 1'b1;
                i_div_busy <= 1'b1;
            end else if (m_run) begin
                if (m_cnt == 0) begin
                    i_div_end_valid <= 1'b1;
                    m_run <= 1'b0;
                    m_drain <= $urandom_range(2, 0);
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end else if (m_drain > 0) begin
                m_drain <= m_drain - 1;
            end else begin
                i_div_busy <= 1'b0;
            end
        end
    end

    // Monitor: start-pulse width and writeback scoreboard
    always @(negedge clk) begin
        logic [36:0] e;
        if (reset) begin
            prev_start = 1'b0;
        end else begin
            if (o_div_start) begin
                check_eq("start_width", {63'd0, prev_start}, 64'd0);
                n_start++;
            end
            prev_start = o_div_start;
            if (o_wb_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("wb_unexpected", {63'd0, o_wb_valid}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("wb_rd", {59'd0, o_wb_rd}, {59'd0, e[36:32]});
                    check_eq("wb_data", {32'd0, o_wb_data}, {32'd0, e[31:0]});
                end
            end
        end
    end

    task automatic present(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
        i_valid = 1'b1; i_funct3 = f3; i_rs1 = a; i_rs2 = b; i_rd = rd;
    endtask

    task automatic idle_inputs();
        i_valid = 1'b0; i_funct3 = 3'd0; i_flush = 1'b0;
    endtask

    // Issue one divide and hold it until EX is released
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        logic [31:0] q, r;
        bit spec, busy0;
        int cyc, starts0;
        rv_div(~f3[0], a, b, q, r);
        exp_q.push_back({rd, f3[1] ? r : q});
        spec = (b == 32'd0) || (!f3[0] && a == c_MIN_NEG && b == c_ALL_ONES);
        starts0 = n_start;
        present(f3, a, b, rd);
        cyc = 0;
        busy0 = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) busy0 = i_div_busy;
            if (!o_stall) break;
            if (cyc > 300) begin
                check_eq("stall_timeout", {63'd0, o_stall}, 64'd0);
                break;
            end
        end
        check_eq("wb_at_stall_drop", {63'd0, o_wb_valid}, 64'd1);
        if (FAST && spec) begin
            check_eq("special_no_start", n_start - starts0, 0);
            if (!busy0) check_eq("special_latency", cyc, 2);
        end else begin
            check_eq("one_start", n_start - starts0, 1);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (o_div_start) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("start_seen", {63'd0, ok}, 64'd1);
    endtask

    initial begin
        bit ok;
        logic [2:0]  f3;
        logic [31:0] a, b;
        reset = 1'b1; i_rs1 = '0; i_rs2 = '0; i_rd = '0;
        idle_inputs();
        repeat (2) @(posedge clk); #1;
        check_eq("rst_stall", {63'd0, o_stall}, 64'd0);
        check_eq("rst_wb_valid", {63'd0, o_wb_valid}, 64'd0);
        check_eq("rst_wb_data", {32'd0, o_wb_data}, 64'd0);
        check_eq("rst_start", {63'd0, o_div_start}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd1);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd2);
        run_op(3'b101, 32'h1234_5678, 32'd0, 5'd3);
        run_op(3'b111, 32'h1234_5678, 32'd0, 5'd4);
        run_op(3'b100, c_MIN_NEG, c_ALL_ONES, 5'd7);
        run_op(3'b110, c_MIN_NEG, c_ALL_ONES, 5'd8);
        run_op(3'b101, c_MIN_NEG, c_ALL_ONES, 5'd9);

        // Flush five cycles into WAIT
        lat_min = 12; lat_max = 14;
        present(3'b100, 32'd1000, 32'd3, 5'd10);
        wait_start(ok);
        repeat (5) @(posedge clk); #1;
        i_flush = 1'b1;
        @(negedge clk);
        check_eq("flush_div_flush", {63'd0, o_div_flush}, 64'd1);
        check_eq("flush_no_wb", {63'd0, o_wb_valid}, 64'd0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check_eq("flush_idle_stall", {63'd0, o_stall}, 64'd0);
        check_eq("flush_no_start", {63'd0, o_div_start}, 64'd0);
        lat_min = 2; lat_max = 8;
        run_op(3'b101, 32'd100, 32'd7, 5'd11);

        // Flush during DONE of a locally resolved op suppresses writeback
        present(3'b101, 32'd55, 32'd0, 5'd12);
        @(posedge clk); #1;
        i_flush = 1'b1;
        @(negedge clk);
        check_eq("done_flush_no_wb", {63'd0, o_wb_valid}, 64'd0);
        @(posedge clk); #1;
        idle_inputs();

        // Asynchronous reset mid-WAIT
        lat_min = 12; lat_max = 14;
        present(3'b100, 32'd999, 32'd4, 5'd13);
        wait_start(ok);
        repeat (3) @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check_eq("arst_stall", {63'd0, o_stall}, 64'd0);
        check_eq("arst_wb_valid", {63'd0, o_wb_valid}, 64'd0);
        check_eq("arst_wb_data", {32'd0, o_wb_data}, 64'd0);
        check_eq("arst_wb_rd", {59'd0, o_wb_rd}, 64'd0);
        check_eq("arst_start", {63'd0, o_div_start}, 64'd0);
        check_eq("arst_dividend", {32'd0, o_div_dividend}, 64'd0);
        check_eq("arst_divisor", {32'd0, o_div_divisor}, 64'd0);
        check_eq("arst_signed", {63'd0, o_div_signed}, 64'd0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        lat_min = 2; lat_max = 8;
        run_op(3'b111, 32'd100, 32'd7, 5'd14);

        // Back-to-back
        run_op(3'b111, 32'd100, 32'd7, 5'd5);
        run_op(3'b101, 32'd100, 32'd7, 5'd6);

        // Randomised traffic with non-divide gaps
        for (int n = 0; n < 150; n++) begin
            f3 = 3'b100 | 3'($urandom_range(3, 0));
            a = $urandom();
            b = $urandom();
            case ($urandom_range(5, 0))
                0: b = 32'd0;
                1: begin a = c_MIN_NEG; b = c_ALL_ONES; end
                2: begin a = $urandom_range(200, 0); b = $urandom_range(20, 1); end
                3: b = 32'($signed($urandom_range(9, 0)) - 5);
                default: ;
            endcase
            run_op(f3, a, b, 5'($urandom_range(31, 0)));
            for (int g = 0; g < int'($urandom_range(2, 0)); g++) begin
                i_valid = 1'($urandom_range(1, 0));
                i_funct3 = 3'($urandom_range(3, 0));
                i_rs1 = $urandom(); i_rs2 = $urandom();
                @(negedge clk);
                check_eq("nondiv_stall", {63'd0, o_stall}, 64'd0);
                @(posedge clk); #1;
                idle_inputs();
            end
        end

        repeat (20) @(posedge clk);
        check_eq("pending_results", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
